message_build_param: RTL and testbench

- Parametrised SHA-2 message padding engine; successor to the fixed 512-bit message builder.
- Takes a per-message config beat carrying the total bit length and a stream of BLOCK_W-bit message beats.
- Emits BLOCK_W-bit padded blocks: the message, a single '1' bit, zero fill, then the big-endian length field.
- Feeds the hash core; BLOCK_W=512 serves SHA-224/256 and BLOCK_W=1024 serves SHA-384/512.

---
 rtl/message_build_param.sv | 224 ++++++++++++++++++++++
 tb/tb_message_build_param.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_build_param.sv
// -----------------------------------------------------------------------------
// message_build_param
//
// SHA-2 message padding engine. A config beat gives the message length in
// bits. BLOCK_W-bit message beats are then turned into padded blocks: the
// message bits, a single '1' bit, zero fill, and the big-endian length in the
// low LEN_W bits of the final block. BLOCK_W=512 serves SHA-224/256 and
// BLOCK_W=1024 serves SHA-384/512.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   cfg_size       message length in bits (64)
//   cfg_valid/ready  config handshake
//   data_in        message beat, MSB-first (BLOCK_W)
//   data_in_last   final beat of the message
//   data_in_valid/ready  beat handshake
//   data_out       padded block (BLOCK_W)
//   data_out_last  final block of the message
//   data_out_valid/ready block handshake
//   err_len        sticky beat-count mismatch flag
//
// Build option MESSAGE_BUILD_LEN_CHECK_EN: when defined, beats are counted
// against max(1, ceil(size/BLOCK_W)). A last flag on the wrong beat sets
// err_len. An early last is padded normally. A missing last makes the expected
// final beat act as last, and the surplus beats are swallowed up to and
// including the one carrying data_in_last. When undefined, err_len is 0 and
// only data_in_last ends a message.
// -----------------------------------------------------------------------------
module message_build_param #(
   parameter int BLOCK_W = 512,
   parameter int LEN_W   = (BLOCK_W == 1024) ? 128 : 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [63:0]        cfg_size,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [BLOCK_W-1:0] data_in,
   input  logic               data_in_last,
   input  logic               data_in_valid,
   output logic               data_in_ready,
   output logic [BLOCK_W-1:0] data_out,
   output logic               data_out_last,
   output logic               data_out_valid,
   input  logic               data_out_ready,
   output logic               err_len
);

   localparam int IDX_W = $clog2(BLOCK_W);
   localparam logic [BLOCK_W-1:0] MSB_ONE  = {1'b1, {(BLOCK_W-1){1'b0}}};
   localparam logic [BLOCK_W-1:0] ALL_ONES = {BLOCK_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;
   typedef enum logic {PAD_ONE, PAD_LEN} pad_t;

   state_t             r_state;
   pad_t               r_pad_kind;
   logic [63:0]        r_size;
   logic [IDX_W-1:0]   r_rem;
   logic               r_cfg_ready;
   logic [BLOCK_W-1:0] r_out_data;
   logic               r_out_last;
   logic               r_out_valid;

   logic               w_out_free;
   logic               w_drop;
   logic               w_final_beat;
   logic               w_cfg_fire;
   logic               w_beat_fire;
   logic               w_len_fits;
   logic [BLOCK_W-1:0] w_keep_mask;
   logic [BLOCK_W-1:0] w_tail_blk;
   logic [BLOCK_W-1:0] w_len_blk;

   // Output register can take a new block when empty or draining this cycle.
   assign w_out_free = !r_out_valid || data_out_ready;

`ifdef MESSAGE_BUILD_LEN_CHECK_EN
   logic [63:0] r_beat_cnt;
   logic [63:0] r_exp_beats;
   logic        r_drop;
   logic        r_err_len;
   logic [63:0] w_cfg_exp;
   logic [63:0] w_beat_num;
   logic        w_cnt_hit;
   logic        w_len_bad;

   // max(1, ceil(size/BLOCK_W)) without risking overflow of size + BLOCK_W-1
   assign w_cfg_exp  = (cfg_size == 64'd0) ? 64'd1 :
                       (cfg_size >> IDX_W) + {63'd0, |cfg_size[IDX_W-1:0]};
   assign w_beat_num = r_beat_cnt + 64'd1;
   assign w_cnt_hit  = (w_beat_num == r_exp_beats);
   assign w_len_bad  = (data_in_last != w_cnt_hit);
   assign w_final_beat = data_in_last || w_cnt_hit;
   assign w_drop     = r_drop;
   assign err_len    = r_err_len;
`else
   assign w_final_beat = data_in_last;
   assign w_drop       = 1'b0;
   assign err_len      = 1'b0;
`endif

   // A new config is held off while surplus beats of the previous message
   // are still being swallowed, so they cannot be mistaken for new data.
   assign cfg_ready     = r_cfg_ready && !w_drop;
   assign data_in_ready = ((r_state == S_DATA) && w_out_free) || w_drop;
   assign w_cfg_fire    = cfg_valid && cfg_ready;
   assign w_beat_fire   = (r_state == S_DATA) && data_in_valid && w_out_free;

   // Length field fits in the last data block when r < BLOCK_W-LEN_W.
   assign w_len_fits  = (r_rem < IDX_W'(BLOCK_W - LEN_W));
   assign w_keep_mask = ~(ALL_ONES >> r_rem);
   assign w_tail_blk  = (data_in & w_keep_mask) | (MSB_ONE >> r_rem);
   assign w_len_blk   = {{(BLOCK_W-64){1'b0}}, r_size};

   assign data_out       = r_out_data;
   assign data_out_last  = r_out_last;
   assign data_out_valid = r_out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pad_kind  <= PAD_ONE;
         r_size      <= 64'd0;
         r_rem       <= '0;
         r_cfg_ready <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef MESSAGE_BUILD_LEN_CHECK_EN
         r_beat_cnt  <= 64'd0;
         r_exp_beats <= 64'd0;
         r_drop      <= 1'b0;
         r_err_len   <= 1'b0;
`endif
      end else begin
         // Drain by default; any load below overrides this.
         if (r_out_valid && data_out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_cfg_fire) begin
                  r_size      <= cfg_size;
                  r_rem       <= cfg_size[IDX_W-1:0];
                  r_cfg_ready <= 1'b0;
                  r_state     <= S_DATA;
`ifdef MESSAGE_BUILD_LEN_CHECK_EN
                  r_beat_cnt  <= 64'd0;
                  r_exp_beats <= w_cfg_exp;
`endif
               end else begin
                  r_cfg_ready <= 1'b1;
               end
            end

            S_DATA: begin
               if (w_beat_fire) begin
                  r_out_valid <= 1'b1;
`ifdef MESSAGE_BUILD_LEN_CHECK_EN
                  r_beat_cnt <= w_beat_num;
                  if (w_len_bad) begin
                     r_err_len <= 1'b1;
                  end
                  // Count says final but producer has more: swallow the rest.
                  if (w_cnt_hit && !data_in_last) begin
                     r_drop <= 1'b1;
                  end
`endif
                  if (!w_final_beat) begin
                     r_out_data <= data_in;
                     r_out_last <= 1'b0;
                  end else if (r_size == 64'd0) begin
                     r_out_data  <= MSB_ONE;
                     r_out_last  <= 1'b1;
                     r_cfg_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end else if (r_rem == '0) begin
                     // Full final beat: padding needs a whole extra block.
                     r_out_data <= data_in;
                     r_out_last <= 1'b0;
                     r_pad_kind <= PAD_ONE;
                     r_state    <= S_PAD;
                  end else if (w_len_fits) begin
                     r_out_data  <= w_tail_blk | w_len_blk;
                     r_out_last  <= 1'b1;
                     r_cfg_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     // '1' bit fits but the length spills into an extra block.
                     r_out_data <= w_tail_blk;
                     r_out_last <= 1'b0;
                     r_pad_kind <= PAD_LEN;
                     r_state    <= S_PAD;
                  end
               end
            end

            S_PAD: begin
               if (w_out_free) begin
                  r_out_valid <= 1'b1;
                  r_out_last  <= 1'b1;
                  r_out_data  <= (r_pad_kind == PAD_ONE) ? (MSB_ONE | w_len_blk) : w_len_blk;
                  r_cfg_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase

`ifdef MESSAGE_BUILD_LEN_CHECK_EN
         if (r_drop && data_in_valid && data_in_last) begin
            r_drop <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_message_build_param.sv
module tb_message_build_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // BLOCK_W = 512 instance
   logic [63:0]   a_cfg_size;
   logic          a_cfg_valid, a_cfg_ready;
   logic [511:0]  a_data_in;
   logic          a_data_in_last, a_data_in_valid, a_data_in_ready;
   logic [511:0]  a_data_out;
   logic          a_data_out_last, a_data_out_valid, a_data_out_ready;
   logic          a_err_len;

   // BLOCK_W = 1024 instance
   logic [63:0]   b_cfg_size;
   logic          b_cfg_valid, b_cfg_ready;
   logic [1023:0] b_data_in;
   logic          b_data_in_last, b_data_in_valid, b_data_in_ready;
   logic [1023:0] b_data_out;
   logic          b_data_out_last, b_data_out_valid, b_data_out_ready;
   logic          b_err_len;

   int n_cmp = 0;
   int n_bad = 0;

   message_build_param #(.BLOCK_W(512)) u_dut512 (
      .clk(clk), .rst(rst),
      .cfg_size(a_cfg_size), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
      .data_in(a_data_in), .data_in_last(a_data_in_last),
      .data_in_valid(a_data_in_valid), .data_in_ready(a_data_in_ready),
      .data_out(a_data_out), .data_out_last(a_data_out_last),
      .data_out_valid(a_data_out_valid), .data_out_ready(a_data_out_ready),
      .err_len(a_err_len)
   );

   message_build_param #(.BLOCK_W(1024)) u_dut1024 (
      .clk(clk), .rst(rst),
      .cfg_size(b_cfg_size), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
      .data_in(b_data_in), .data_in_last(b_data_in_last),
      .data_in_valid(b_data_in_valid), .data_in_ready(b_data_in_ready),
      .data_out(b_data_out), .data_out_last(b_data_out_last),
      .data_out_valid(b_data_out_valid), .data_out_ready(b_data_out_ready),
      .err_len(b_err_len)
   );

   // Handshake drivers: start at posedge+1, return at posedge+1 after transfer.
   task automatic a_cfg(input logic [63:0] sz);
      int n = 0;
      a_cfg_size = sz; a_cfg_valid = 1'b1;
      @(negedge clk);
      while (!a_cfg_ready && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (a_cfg_ready !== 1'b1) begin
         n_bad++; $display("FAIL cfg_handshake: cfg_ready=%b required 1", a_cfg_ready);
      end
      @(posedge clk); #1;
      a_cfg_valid = 1'b0;
   endtask

   task automatic a_beat(input logic [511:0] d, input logic last);
      int n = 0;
      a_data_in = d; a_data_in_last = last; a_data_in_valid = 1'b1;
      @(negedge clk);
      while (!a_data_in_ready && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (a_data_in_ready !== 1'b1) begin
         n_bad++; $display("FAIL beat_handshake: data_in_ready=%b required 1", a_data_in_ready);
      end
      @(posedge clk); #1;
      a_data_in_valid = 1'b0; a_data_in_last = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (a_cfg_ready !== 1'b0 || a_data_in_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: cfg_ready=%b data_in_ready=%b required 0 0", a_cfg_ready, a_data_in_ready);
      end
      n_cmp++;
      if (a_data_out_valid !== 1'b0 || a_data_out_last !== 1'b0 || a_data_out !== 512'd0) begin
         n_bad++; $display("FAIL reset_out: valid=%b last=%b data=%h required 0 0 0", a_data_out_valid, a_data_out_last, a_data_out);
      end
      n_cmp++;
      if (a_err_len !== 1'b0 || b_data_out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_misc: err_len=%b b_valid=%b required 0 0", a_err_len, b_data_out_valid);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (a_cfg_ready !== 1'b1 || a_data_in_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle: cfg_ready=%b data_in_ready=%b required 1 0", a_cfg_ready, a_data_in_ready);
      end
      $display("reset: done");
   endtask

   task automatic test_abc();
      logic [511:0] exp_d;
      exp_d = {32'h61626380, 416'd0, 64'h18};
      a_cfg(64'd24);
      a_beat({24'h616263, 488'd0}, 1'b1);
      n_cmp++;
      if (a_data_out_valid !== 1'b1 || a_data_out !== exp_d || a_data_out_last !== 1'b1) begin
         n_bad++; $display("FAIL abc_block: valid=%b last=%b data=%h required 1 1 %h", a_data_out_valid, a_data_out_last, a_data_out, exp_d);
      end
      @(posedge clk); #1;
      $display("abc: size 24 one block");
   endtask

   task automatic test_len_spill();
      logic [511:0] p, exp1, exp2;
      p    = {16{32'hDEADBEEF}};
      exp1 = {p[511:64], 1'b1, 63'd0};
      exp2 = {448'd0, 64'h1C0};
      a_cfg(64'd448);
      a_beat(p, 1'b1);
      n_cmp++;
      if (a_data_out !== exp1 || a_data_out_last !== 1'b0 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s448_blk1: last=%b data=%h required 0 %h", a_data_out_last, a_data_out, exp1);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_data_out !== exp2 || a_data_out_last !== 1'b1 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s448_blk2: last=%b data=%h required 1 %h", a_data_out_last, a_data_out, exp2);
      end
      @(posedge clk); #1;
      $display("len_spill: size 448 two blocks");
   endtask

   task automatic test_full_block();
      logic [511:0] p, exp2;
      p    = {8{64'h0123456789ABCDEF}};
      exp2 = {1'b1, 447'd0, 64'h200};
      a_cfg(64'd512);
      a_beat(p, 1'b1);
      n_cmp++;
      if (a_data_out !== p || a_data_out_last !== 1'b0 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s512_blk1: last=%b data=%h required 0 %h", a_data_out_last, a_data_out, p);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_data_out !== exp2 || a_data_out_last !== 1'b1 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s512_blk2: last=%b data=%h required 1 %h", a_data_out_last, a_data_out, exp2);
      end
      @(posedge clk); #1;
      $display("full_block: size 512 two blocks");
   endtask

   task automatic test_zero_backpressure();
      logic [511:0] exp_d;
      exp_d = {1'b1, 511'd0};
      a_cfg(64'd0);
      a_data_out_ready = 1'b0;
      a_beat({16{32'hFFFF0000}}, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (a_data_out !== exp_d || a_data_out_last !== 1'b1 || a_data_out_valid !== 1'b1 || a_data_in_ready !== 1'b0) begin
            n_bad++; $display("FAIL zero_hold%0d: valid=%b last=%b in_ready=%b data=%h required 1 1 0 %h", i, a_data_out_valid, a_data_out_last, a_data_in_ready, a_data_out, exp_d);
         end
      end
      a_data_out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (a_data_out_valid !== 1'b0) begin
         n_bad++; $display("FAIL zero_drain: valid=%b required 0", a_data_out_valid);
      end
      $display("zero_backpressure: size 0 held 5 cycles");
   endtask

   task automatic test_back_to_back();
      logic [511:0] p, q, exp2;
      p    = {16{32'hA5A55A5A}};
      q    = {8{64'h0123456789ABCDEF}};
      exp2 = {q[511:424], 1'b1, 359'd0, 64'd600};
      a_cfg(64'd600);
      a_beat(p, 1'b0);
      n_cmp++;
      if (a_data_out !== p || a_data_out_last !== 1'b0 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s600_blk1: last=%b data=%h required 0 %h", a_data_out_last, a_data_out, p);
      end
      a_beat(q, 1'b1);
      n_cmp++;
      if (a_data_out !== exp2 || a_data_out_last !== 1'b1 || a_data_out_valid !== 1'b1) begin
         n_bad++; $display("FAIL s600_blk2: last=%b data=%h required 1 %h", a_data_out_last, a_data_out, exp2);
      end
      @(posedge clk); #1;
      $display("back_to_back: size 600 two beats");
   endtask

   task automatic test_wide_block();
      logic [1023:0] exp_d;
      int n = 0;
      exp_d = {24'h616263, 1'b1, 871'd0, 128'h18};
      b_cfg_size = 64'd24; b_cfg_valid = 1'b1;
      @(negedge clk);
      while (!b_cfg_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      b_cfg_valid = 1'b0;
      b_data_in = {24'h616263, 1000'd0}; b_data_in_last = 1'b1; b_data_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_data_in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      b_data_in_valid = 1'b0;
      n_cmp++;
      if (b_data_out[1023:512] !== exp_d[1023:512] || b_data_out_valid !== 1'b1 || b_data_out_last !== 1'b1) begin
         n_bad++; $display("FAIL w1024_hi: valid=%b last=%b data=%h required 1 1 %h", b_data_out_valid, b_data_out_last, b_data_out[1023:512], exp_d[1023:512]);
      end
      n_cmp++;
      if (b_data_out[511:0] !== exp_d[511:0]) begin
         n_bad++; $display("FAIL w1024_lo: data=%h required %h", b_data_out[511:0], exp_d[511:0]);
      end
      @(posedge clk); #1;
      $display("wide_block: 1024-bit size 24");
   endtask

   task automatic test_reset_mid();
      a_cfg(64'd1024);
      a_data_out_ready = 1'b0;
      a_beat({16{32'h12345678}}, 1'b0);
      @(negedge clk); rst = 1'b1;
      #1;
      n_cmp++;
      if (a_data_out_valid !== 1'b0 || a_data_out !== 512'd0 || a_cfg_ready !== 1'b0 || a_data_in_ready !== 1'b0 || a_err_len !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_clear: valid=%b cfg_ready=%b in_ready=%b err=%b data=%h required 0 0 0 0 0", a_data_out_valid, a_cfg_ready, a_data_in_ready, a_err_len, a_data_out);
      end
      @(negedge clk); rst = 1'b0; a_data_out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (a_cfg_ready !== 1'b1 || a_data_out_valid !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_idle: cfg_ready=%b valid=%b required 1 0", a_cfg_ready, a_data_out_valid);
      end
      $display("reset_mid: DATA state cleared");
   endtask

   task automatic test_early_last();
      logic [511:0] p, exp2;
      logic exp_err;
`ifdef MESSAGE_BUILD_LEN_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      p    = {16{32'hCAFEF00D}};
      exp2 = {1'b1, 447'd0, 64'h400};
      pulse_reset();
      a_cfg(64'd1024);
      a_beat(p, 1'b1);
      n_cmp++;
      if (a_data_out !== p || a_data_out_last !== 1'b0 || a_err_len !== exp_err) begin
         n_bad++; $display("FAIL early_blk1: last=%b err=%b data=%h required 0 %b %h", a_data_out_last, a_err_len, a_data_out, exp_err, p);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_data_out !== exp2 || a_data_out_last !== 1'b1 || a_data_out_valid !== 1'b1 || a_err_len !== exp_err) begin
         n_bad++; $display("FAIL early_blk2: last=%b err=%b data=%h required 1 %b %h", a_data_out_last, a_err_len, a_data_out, exp_err, exp2);
      end
      @(posedge clk); #1;
      $display("early_last: size 1024 last on beat 1");
   endtask

`ifdef MESSAGE_BUILD_LEN_CHECK_EN
   task automatic test_missing_last();
      logic [511:0] exp_d;
      exp_d = {32'h61626380, 416'd0, 64'h18};
      pulse_reset();
      a_cfg(64'd24);
      a_beat({24'h616263, 488'd0}, 1'b0);
      n_cmp++;
      if (a_data_out !== exp_d || a_data_out_last !== 1'b1 || a_err_len !== 1'b1) begin
         n_bad++; $display("FAIL missing_blk: last=%b err=%b data=%h required 1 1 %h", a_data_out_last, a_err_len, a_data_out, exp_d);
      end
      a_beat({16{32'hFFFFFFFF}}, 1'b1);
      n_cmp++;
      if (a_data_out_valid !== 1'b0 || a_cfg_ready !== 1'b1) begin
         n_bad++; $display("FAIL missing_drop: valid=%b cfg_ready=%b required 0 1", a_data_out_valid, a_cfg_ready);
      end
      $display("missing_last: surplus beat dropped");
   endtask
`endif

   initial begin
      rst = 1'b1;
      a_cfg_size = '0; a_cfg_valid = 1'b0; a_data_in = '0; a_data_in_last = 1'b0;
      a_data_in_valid = 1'b0; a_data_out_ready = 1'b1;
      b_cfg_size = '0; b_cfg_valid = 1'b0; b_data_in = '0; b_data_in_last = 1'b0;
      b_data_in_valid = 1'b0; b_data_out_ready = 1'b1;

      test_reset();
      test_abc();
      test_len_spill();
      test_full_block();
      test_zero_backpressure();
      test_back_to_back();
      test_wide_block();
      test_reset_mid();
      test_early_last();
`ifdef MESSAGE_BUILD_LEN_CHECK_EN
      test_missing_last();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
